// File: rtl/tpumac_row.sv
// One row of signed MAC cells: A ripples left-to-right one column per enabled
// cycle, B and C are per column, with optional saturation and sticky overflow.
module tpumac_row #(
  parameter int COLS     = 4,
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic [BITS_AB-1:0]        Ain,
  input  logic [COLS*BITS_AB-1:0]   Bin,
  input  logic [COLS*BITS_C-1:0]    Cin,
  output logic [BITS_AB-1:0]        Aout,
  output logic [COLS*BITS_AB-1:0]   Bout,
  output logic [COLS*BITS_C-1:0]    Cout,
  output logic [COLS-1:0]           ovf
);

  localparam int PW = 2 * BITS_AB;
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  // Registered A of every column; column gi reads column gi-1 as its input.
  logic [COLS-1:0][BITS_AB-1:0] a_tap;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [BITS_AB-1:0]        a_reg;
      logic [BITS_AB-1:0]        b_reg;
      logic [BITS_C-1:0]         c_reg;
      logic [BITS_C-1:0]         c_next;
      logic [BITS_C-1:0]         c_acc;
      logic                      ovf_reg;
      logic                      ovf_next;
      logic signed [BITS_AB-1:0] a_col;
      logic signed [BITS_AB-1:0] b_col;
      logic signed [PW-1:0]      prod;
      logic [BITS_C:0]           sum;
      logic                      sum_ovf;

      if (gi == 0) begin : g_head
        assign a_col = Ain;
      end else begin : g_tail
        assign a_col = a_tap[gi-1];
      end

      assign b_col = Bin[gi*BITS_AB +: BITS_AB];

      // Multiply the operands arriving this cycle, not the registered copies.
      assign prod = a_col * b_col;

      // One guard bit is enough: |prod| is far below 2^BITS_C.
      assign sum = {c_reg[BITS_C-1], c_reg}
                 + {{(BITS_C+1-PW){prod[PW-1]}}, prod};
      assign sum_ovf = sum[BITS_C] ^ sum[BITS_C-1];

      always_comb begin
        c_acc = sum[BITS_C-1:0];
        if (SATURATE != 0 && sum_ovf) begin
          c_acc = sum[BITS_C] ? C_MIN : C_MAX;
        end
      end

      always_comb begin
        c_next   = c_reg;
        ovf_next = ovf_reg;
        if (clr) begin
          c_next   = '0;
          ovf_next = 1'b0;
        end else if (WrEn) begin
          c_next   = Cin[gi*BITS_C +: BITS_C];
          ovf_next = 1'b0;
        end else if (en) begin
          c_next   = c_acc;
          ovf_next = ovf_reg | sum_ovf;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg   <= '0;
          b_reg   <= '0;
          c_reg   <= '0;
          ovf_reg <= 1'b0;
        end else begin
          // A/B shift on en regardless of clr/WrEn.
          if (en) begin
            a_reg <= a_col;
            b_reg <= b_col;
          end
          c_reg   <= c_next;
          ovf_reg <= ovf_next;
        end
      end

      assign a_tap[gi]                    = a_reg;
      assign Bout[gi*BITS_AB +: BITS_AB]  = b_reg;
      assign Cout[gi*BITS_C +: BITS_C]    = c_reg;
      assign ovf[gi]                      = ovf_reg;
    end
  endgenerate

  assign Aout = a_tap[COLS-1];

endmodule

// File: tb/tb_tpumac_row.sv
// Scoreboard bench for tpumac_row: wrap and saturate instances run side by
// side against an integer reference model of the row.
module tb_tpumac_row;
  localparam int COLS = 4;
  localparam int BA   = 8;
  localparam int BC   = 16;
  localparam longint CMAX = (longint'(1) << (BC-1)) - 1;
  localparam longint CMIN = -(longint'(1) << (BC-1));
  localparam longint CSPAN = longint'(1) << BC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic wr_en = 1'b0;
  logic clr = 1'b0;
  logic [BA-1:0]      ain = '0;
  logic [COLS*BA-1:0] bin = '0;
  logic [COLS*BC-1:0] cin = '0;

  logic [BA-1:0]      aout_w, aout_s;
  logic [COLS*BA-1:0] bout_w, bout_s;
  logic [COLS*BC-1:0] cout_w, cout_s;
  logic [COLS-1:0]    ovf_w, ovf_s;

  tpumac_row #(.COLS(COLS), .BITS_AB(BA), .BITS_C(BC), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(wr_en), .clr(clr),
    .Ain(ain), .Bin(bin), .Cin(cin),
    .Aout(aout_w), .Bout(bout_w), .Cout(cout_w), .ovf(ovf_w));

  tpumac_row #(.COLS(COLS), .BITS_AB(BA), .BITS_C(BC), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(wr_en), .clr(clr),
    .Ain(ain), .Bin(bin), .Cin(cin),
    .Aout(aout_s), .Bout(bout_s), .Cout(cout_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BA-1:0]      aout;
    logic [COLS*BA-1:0] bout;
    logic [COLS*BC-1:0] cout_w;
    logic [COLS*BC-1:0] cout_s;
    logic [COLS-1:0]    ovf_w;
    logic [COLS-1:0]    ovf_s;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: plain signed integers per column.
  int ma[COLS];
  int mb[COLS];
  int mcw[COLS];
  int mcs[COLS];
  bit mow[COLS];
  bit mos[COLS];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  function automatic int acc(input int c, input int p, input bit sat, output bit of);
    longint s;
    s  = longint'(c) + longint'(p);
    of = (s > CMAX) || (s < CMIN);
    if (of) begin
      if (sat) s = (s > CMAX) ? CMAX : CMIN;
      else     s = (s > CMAX) ? s - CSPAN : s + CSPAN;
    end
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < COLS; j++) begin
      ma[j] = 0; mb[j] = 0; mcw[j] = 0; mcs[j] = 0; mow[j] = 0; mos[j] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit w, input bit c);
    int acol[COLS];
    int bj;
    int cj;
    bit of;
    for (int j = 0; j < COLS; j++)
      acol[j] = (j == 0) ? int'($signed(ain)) : ma[j-1];
    for (int j = 0; j < COLS; j++) begin
      bj = int'($signed(bin[j*BA +: BA]));
      cj = int'($signed(cin[j*BC +: BC]));
      if (c) begin
        mcw[j] = 0; mcs[j] = 0; mow[j] = 0; mos[j] = 0;
      end else if (w) begin
        mcw[j] = cj; mcs[j] = cj; mow[j] = 0; mos[j] = 0;
      end else if (e) begin
        mcw[j] = acc(mcw[j], acol[j] * bj, 1'b0, of);
        mow[j] = mow[j] | of;
        mcs[j] = acc(mcs[j], acol[j] * bj, 1'b1, of);
        mos[j] = mos[j] | of;
      end
    end
    if (e) begin
      for (int j = 0; j < COLS; j++) begin
        ma[j] = acol[j];
        mb[j] = int'($signed(bin[j*BA +: BA]));
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.aout = ma[COLS-1][BA-1:0];
    for (int j = 0; j < COLS; j++) begin
      e.bout[j*BA +: BA]   = mb[j][BA-1:0];
      e.cout_w[j*BC +: BC] = mcw[j][BC-1:0];
      e.cout_s[j*BC +: BC] = mcs[j][BC-1:0];
      e.ovf_w[j]           = mow[j];
      e.ovf_s[j]           = mos[j];
    end
    return e;
  endfunction

  // One clock of stimulus; expectation is queued right after the edge.
  task automatic step(input bit e, input bit w, input bit c, input logic [BA-1:0] a,
                      input logic [COLS*BA-1:0] b, input logic [COLS*BC-1:0] ci);
    en = e; wr_en = w; clr = c; ain = a; bin = b; cin = ci;
    @(posedge clk);
    model_step(e, w, c);
    exp_q.push_back(snapshot());
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aout_w"}, 64'(aout_w), 64'd0);
    chk({tag, "_bout_w"}, 64'(bout_w), 64'd0);
    chk({tag, "_cout_w"}, 64'(cout_w), 64'd0);
    chk({tag, "_ovf_w"},  64'(ovf_w),  64'd0);
    chk({tag, "_aout_s"}, 64'(aout_s), 64'd0);
    chk({tag, "_bout_s"}, 64'(bout_s), 64'd0);
    chk({tag, "_cout_s"}, 64'(cout_s), 64'd0);
    chk({tag, "_ovf_s"},  64'(ovf_s),  64'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_all_zero(tag);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every falling edge with a pending expectation is one transaction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d en=%0b wr=%0b clr=%0b cout_w=%h cout_s=%h ovf_w=%b ovf_s=%b",
                 txn, en, wr_en, clr, cout_w, cout_s, ovf_w, ovf_s);
        chk("sb_aout_w", 64'(aout_w), 64'(e.aout));
        chk("sb_aout_s", 64'(aout_s), 64'(e.aout));
        chk("sb_bout_w", 64'(bout_w), 64'(e.bout));
        chk("sb_bout_s", 64'(bout_s), 64'(e.bout));
        chk("sb_cout_w", 64'(cout_w), 64'(e.cout_w));
        chk("sb_cout_s", 64'(cout_s), 64'(e.cout_s));
        chk("sb_ovf_w",  64'(ovf_w),  64'(e.ovf_w));
        chk("sb_ovf_s",  64'(ovf_s),  64'(e.ovf_s));
      end
    end
  end

  initial begin : stim
    logic [COLS*BA-1:0] b3;
    b3 = {COLS{8'd3}};
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset_initial");
    rst_n = 1'b1;

    // Reset mid-accumulation, then a single enabled edge.
    step(1'b1, 1'b0, 1'b0, 8'd5, {COLS{8'd7}}, '0);
    step(1'b1, 1'b0, 1'b0, 8'd6, {COLS{8'd9}}, '0);
    reset_pulse("reset_mid");
    step(1'b1, 1'b0, 1'b0, 8'd3, b3, '0);
    chk("first_cout", 64'(cout_w), 64'({16'd0, 16'd0, 16'd0, 16'd9}));
    chk("first_bout", 64'(bout_w), 64'(32'h03030303));
    chk("first_aout", 64'(aout_w), 64'd0);

    // Skew: four enabled edges in total, then a three-cycle stall.
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'd3, b3, '0);
    chk("skew_cout", 64'(cout_w), 64'({16'd9, 16'd18, 16'd27, 16'd36}));
    chk("skew_aout", 64'(aout_w), 64'd3);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h5A, {COLS{8'h77}}, '0);
    chk("stall_cout", 64'(cout_w), 64'({16'd9, 16'd18, 16'd27, 16'd36}));

    // Load and priority.
    step(1'b0, 1'b1, 1'b0, 8'd0, '0, {48'h0, 16'h0100});
    chk("load_c0", 64'(cout_w[15:0]), 64'(16'h0100));
    chk("load_bhold", 64'(bout_w), 64'(32'h03030303));
    step(1'b1, 1'b1, 1'b0, 8'h11, {COLS{8'h02}}, {16'h4, 16'h3, 16'h2, 16'h1});
    chk("load_en_c", 64'(cout_w), 64'({16'h4, 16'h3, 16'h2, 16'h1}));
    chk("load_en_aout", 64'(aout_w), 64'd3);
    chk("load_en_bout", 64'(bout_w), 64'(32'h02020202));
    step(1'b0, 1'b1, 1'b1, 8'd0, '0, {COLS{16'h1234}});
    chk("clr_wins", 64'(cout_w), 64'd0);

    // Signed product.
    step(1'b0, 1'b1, 1'b0, 8'd0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 8'hFE, {24'h0, 8'd5}, '0);
    chk("signed_c0", 64'(cout_w[15:0]), 64'(16'hFFF6));
    chk("signed_ovf", 64'(ovf_w[0]), 64'd0);

    // Positive overflow, sticky flag, clear.
    step(1'b0, 1'b1, 1'b0, 8'd0, '0, {48'h0, 16'd32760});
    step(1'b1, 1'b0, 1'b0, 8'd127, {24'h0, 8'd127}, '0);
    chk("wrap_c0", 64'(cout_w[15:0]), 64'(16'hBEF9));
    chk("wrap_ovf", 64'(ovf_w[0]), 64'd1);
    chk("sat_c0", 64'(cout_s[15:0]), 64'(16'h7FFF));
    chk("sat_ovf", 64'(ovf_s[0]), 64'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0, {24'h0, 8'd1}, '0);
    chk("sticky_w", 64'(ovf_w[0]), 64'd1);
    chk("sticky_s", 64'(ovf_s[0]), 64'd1);
    step(1'b0, 1'b0, 1'b1, 8'd0, '0, '0);
    chk("clr_ovf_w", 64'(ovf_w), 64'd0);
    chk("clr_ovf_s", 64'(ovf_s), 64'd0);

    // Negative overflow.
    step(1'b0, 1'b1, 1'b0, 8'd0, '0, {48'h0, 16'h8008});
    step(1'b1, 1'b0, 1'b0, 8'h80, {24'h0, 8'd127}, '0);
    chk("negsat_c0", 64'(cout_s[15:0]), 64'(16'h8000));
    chk("negsat_ovf", 64'(ovf_s), 64'(4'b0001));
    chk("negwrap_c0", 64'(cout_w[15:0]), 64'(16'h4088));
    chk("negwrap_ovf", 64'(ovf_w), 64'(4'b0001));

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse("reset_rand");
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 4, 8'($urandom_range(0, 255)),
           32'($urandom), {32'($urandom), 32'($urandom)});
    end

    en = 1'b0; wr_en = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
